// File: rtl/up_spi_pkg.sv
// Shared register map, control words and state encodings for the up-bus SPI sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package up_spi_pkg;

  // Register map of the SPI controller behind the up-bus
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_TXDATA = 4'd2;
  localparam logic [3:0] REG_DIV    = 4'd3;

  // Control word base and the extra bits that start a transfer
  localparam logic [31:0] CTRL_BASE = 32'h0001_0800;
  localparam logic [31:0] GO_MASK   = 32'h0000_0009;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_SEL,
    ST_DATA,
    ST_GO,
    ST_POLL,
    ST_RSP
  } seq_state_e;

  typedef enum logic {
    X_IDLE,
    X_WAIT
  } xfer_state_e;

  // Control word with the chip-select index placed at bits [2:1]
  function automatic logic [31:0] ctrl_word(input logic [1:0] cs);
    return CTRL_BASE | {29'd0, cs, 1'b0};
  endfunction

endpackage

// File: rtl/up_bus_xfer.sv
// Single up-bus access: one-cycle request pulse, then wait for the matching ack or time out.
// Latency: request in the start cycle; done/tmo combinational with the ack / last wait cycle.
// Backpressure: start is ignored while an access is outstanding; acks ignored when not waiting.
module up_bus_xfer
  import up_spi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int ACK_TMO       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     rd_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     wack_i,
  input  logic                     rack_i,
  output logic                     wreq_o,
  output logic [ADDRESS_WIDTH-1:0] waddr_o,
  output logic [31:0]              wdata_o,
  output logic                     rreq_o,
  output logic [ADDRESS_WIDTH-1:0] raddr_o,
  output logic                     done_o,
  output logic                     tmo_o
);

  localparam int CW = $clog2(ACK_TMO + 1);

  xfer_state_e              state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     rd_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q;

  logic                     issue, waiting, active, cur_rd, ack;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [31:0]              cur_wdata;
  logic [CW-1:0]            cur_cnt;

  // The issue cycle is the first ack-wait cycle, so an ack there completes the access
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = (state_q == X_IDLE) && start_i;
    waiting   = (state_q == X_WAIT);
    active    = issue || waiting;
    cur_rd    = issue ? rd_i    : rd_q;
    cur_addr  = issue ? addr_i  : addr_q;
    cur_wdata = issue ? wdata_i : wdata_q;
    cur_cnt   = waiting ? cnt_q : '0;
    ack       = active && (cur_rd ? rack_i : wack_i);
    tmo_o     = active && !ack && (cur_cnt == CW'(ACK_TMO - 1));
    done_o    = ack;
    wreq_o    = issue && !rd_i;
    rreq_o    = issue && rd_i;
    waddr_o   = (active && !cur_rd) ? cur_addr  : '0;
    wdata_o   = (active && !cur_rd) ? cur_wdata : '0;
    raddr_o   = (active &&  cur_rd) ? cur_addr  : '0;
    if (active) begin
      if (ack || tmo_o) begin
        state_d = X_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = X_WAIT;
        cnt_d   = cur_cnt + CW'(1);
      end
    end
  end

  // Handshake state and wait-cycle counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= X_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold the request fields so address/data stay stable until the ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      rd_q    <= rd_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

endmodule

// File: rtl/up_spi_seq.sv
// Sequences one SPI byte transfer as up-bus register writes, then polls status until idle.
// Latency: 3-4 write accesses plus >=1 status read, one RSP cycle; each access bounded by ACK_TMO.
// Backpressure: cmd_ready only in IDLE; bus stalls handled by waiting for wack/rack with timeout.
module up_spi_seq
  import up_spi_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 12,
  parameter logic [15:0] DIV_RESET     = 16'h0004,
  parameter int          ACK_TMO       = 16,
  parameter int          POLL_MAX      = 1024
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_cs,
  input  logic [7:0]               cmd_data,
  input  logic [15:0]              cmd_div,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic                     m_up_wreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_waddr,
  output logic [31:0]              m_up_wdata,
  input  logic                     m_up_wack,
  output logic                     m_up_rreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_raddr,
  input  logic [31:0]              m_up_rdata,
  input  logic                     m_up_rack
);

  localparam int PW = $clog2(POLL_MAX + 1);

  seq_state_e   state_q, state_d;
  logic [1:0]   cs_q, cs_d;
  logic [7:0]   data_q, data_d;
  logic [15:0]  div_q, div_d;
  logic [15:0]  last_div_q, last_div_d;
  logic         div_vld_q, div_vld_d;
  logic [31:0]  status_q, status_d;
  logic         err_q, err_d;
  logic [PW-1:0] poll_q, poll_d;

  logic                     x_start, x_rd, x_done, x_tmo;
  logic [ADDRESS_WIDTH-1:0] x_addr;
  logic [31:0]              x_wdata;

  up_bus_xfer #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .ACK_TMO       (ACK_TMO)
  ) u_xfer (
    .clk_i   (up_clk),
    .rst_i   (up_rst),
    .start_i (x_start),
    .rd_i    (x_rd),
    .addr_i  (x_addr),
    .wdata_i (x_wdata),
    .wack_i  (m_up_wack),
    .rack_i  (m_up_rack),
    .wreq_o  (m_up_wreq),
    .waddr_o (m_up_waddr),
    .wdata_o (m_up_wdata),
    .rreq_o  (m_up_rreq),
    .raddr_o (m_up_raddr),
    .done_o  (x_done),
    .tmo_o   (x_tmo)
  );

  // Next-state, access selection and response outputs
  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    data_d     = data_q;
    div_d      = div_q;
    last_div_d = last_div_q;
    div_vld_d  = div_vld_q;
    status_d   = status_q;
    err_d      = err_q;
    poll_d     = poll_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    x_start    = 1'b0;
    x_rd       = 1'b0;
    x_addr     = '0;
    x_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cs_d     = cmd_cs;
          data_d   = cmd_data;
          div_d    = cmd_div;
          status_d = '0;
          err_d    = 1'b0;
          poll_d   = '0;
          state_d  = (div_vld_q && (cmd_div == last_div_q)) ? ST_SEL : ST_DIV;
        end
      end
      ST_DIV: begin
        x_start = 1'b1;
        x_addr  = ADDRESS_WIDTH'(REG_DIV);
        x_wdata = {16'd0, div_q};
        if (x_done) begin
          last_div_d = div_q;
          div_vld_d  = 1'b1;
          state_d    = ST_SEL;
        end else if (x_tmo) begin
          // The divider register content is unknown now; force a rewrite next time
          div_vld_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_RSP;
        end
      end
      ST_SEL, ST_DATA, ST_GO: begin
        x_start = 1'b1;
        if (state_q == ST_SEL) begin
          x_addr  = ADDRESS_WIDTH'(REG_CTRL);
          x_wdata = ctrl_word(cs_q);
        end else if (state_q == ST_DATA) begin
          x_addr  = ADDRESS_WIDTH'(REG_TXDATA);
          x_wdata = {24'd0, data_q};
        end else begin
          x_addr  = ADDRESS_WIDTH'(REG_CTRL);
          x_wdata = ctrl_word(cs_q) | GO_MASK;
        end
        if (x_done) begin
          state_d = (state_q == ST_SEL)  ? ST_DATA :
                    (state_q == ST_DATA) ? ST_GO   : ST_POLL;
        end else if (x_tmo) begin
          err_d   = 1'b1;
          state_d = ST_RSP;
        end
      end
      ST_POLL: begin
        // The sub-module only issues when idle, so this re-reads right after each busy rack
        x_start = 1'b1;
        x_rd    = 1'b1;
        x_addr  = ADDRESS_WIDTH'(REG_STATUS);
        if (x_done) begin
          status_d = m_up_rdata;
          poll_d   = poll_q + PW'(1);
          if (!m_up_rdata[0]) begin
            state_d = ST_RSP;
          end else if (poll_q == PW'(POLL_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = ST_RSP;
          end
        end else if (x_tmo) begin
          err_d   = 1'b1;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_data = rsp_valid ? status_q : '0;
    rsp_err  = rsp_valid ? err_q    : 1'b0;
  end

  // Sequencer state, latched command fields, divider cache and results
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state_q    <= ST_IDLE;
      cs_q       <= '0;
      data_q     <= '0;
      div_q      <= '0;
      last_div_q <= DIV_RESET;
      div_vld_q  <= 1'b1;
      status_q   <= '0;
      err_q      <= 1'b0;
      poll_q     <= '0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      data_q     <= data_d;
      div_q      <= div_d;
      last_div_q <= last_div_d;
      div_vld_q  <= div_vld_d;
      status_q   <= status_d;
      err_q      <= err_d;
      poll_q     <= poll_d;
    end
  end

endmodule

// File: tb/tb_up_spi_seq.sv
// Directed bench for up_spi_seq with a bus responder and write/response scoreboards.
// Latency: checks timeout response timing against the unanswered request cycle.
// Backpressure: responder latency, withheld acks and busy status are configured per step.
module tb_up_spi_seq;

  localparam int AW       = 12;
  localparam int ACK_TMO  = 16;
  localparam int POLL_MAX = 1024;

  logic          up_clk = 1'b0;
  logic          up_rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_cs = '0;
  logic [7:0]    cmd_data = '0;
  logic [15:0]   cmd_div = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          m_up_wreq;
  logic [AW-1:0] m_up_waddr;
  logic [31:0]   m_up_wdata;
  logic          m_up_wack = 1'b0;
  logic          m_up_rreq;
  logic [AW-1:0] m_up_raddr;
  logic [31:0]   m_up_rdata = '0;
  logic          m_up_rack = 1'b0;

  always #5 up_clk = ~up_clk;

  up_spi_seq #(
    .ADDRESS_WIDTH (AW),
    .DIV_RESET     (16'h0004),
    .ACK_TMO       (ACK_TMO),
    .POLL_MAX      (POLL_MAX)
  ) dut (
    .up_clk     (up_clk),
    .up_rst     (up_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_cs     (cmd_cs),
    .cmd_data   (cmd_data),
    .cmd_div    (cmd_div),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .m_up_wreq  (m_up_wreq),
    .m_up_waddr (m_up_waddr),
    .m_up_wdata (m_up_wdata),
    .m_up_wack  (m_up_wack),
    .m_up_rreq  (m_up_rreq),
    .m_up_raddr (m_up_raddr),
    .m_up_rdata (m_up_rdata),
    .m_up_rack  (m_up_rack)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          reads;
    logic        tmo_chk;
  } rsp_t;

  wr_t  wr_q[$];
  rsp_t rsp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Responder configuration, written by the stimulus
  int wack_lat   = 1;
  int rack_lat   = 1;
  bit wack_hold  = 1'b0;
  int busy_reads = 0;
  bit spur       = 1'b0;

  // Responder / monitor state
  int            wcnt = 0, rcnt = 0, rd_cnt = 0, rsp_seen = 0, last_wreq_cyc = 0;
  bit            wbusy = 1'b0, rbusy = 1'b0, rsp_prev = 1'b0;
  logic [AW-1:0] cur_waddr = '0;
  logic [31:0]   cur_wdata = '0;

  // Reference divider cache
  logic [15:0] m_div = 16'h0004;
  bit          m_div_vld = 1'b1;

  always @(posedge up_clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor first (outputs of this cycle), then responder drives acks for this cycle
  always @(negedge up_clk) begin
    wr_t  w;
    rsp_t e;
    if (up_rst) begin
      wcnt = 0; rcnt = 0; rd_cnt = 0;
      wbusy = 1'b0; rbusy = 1'b0; rsp_prev = 1'b0;
      m_up_wack = 1'b0; m_up_rack = 1'b0;
    end else begin
      if (rsp_prev) check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
      rsp_prev = rsp_valid;
      if (rsp_valid) begin
        wbusy = 1'b0;
        rbusy = 1'b0;
        check("rsp_expected", {31'd0, rsp_q.size() != 0}, 32'd1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rreq_count", rd_cnt, e.reads);
          if (e.tmo_chk) check("tmo_latency", cyc - last_wreq_cyc, ACK_TMO);
        end
        rd_cnt = 0;
        rsp_seen++;
      end
      check("req_excl", {31'd0, m_up_wreq & m_up_rreq}, 32'd0);
      if (m_up_wreq) begin
        check("wr_expected", {31'd0, wr_q.size() != 0}, 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_addr", {20'd0, m_up_waddr}, {20'd0, w.addr});
          check("wr_data", m_up_wdata, w.data);
        end
        cur_waddr = m_up_waddr;
        cur_wdata = m_up_wdata;
        wbusy = 1'b1;
        last_wreq_cyc = cyc;
      end else if (wbusy) begin
        check("waddr_hold", {20'd0, m_up_waddr}, {20'd0, cur_waddr});
        check("wdata_hold", m_up_wdata, cur_wdata);
      end else begin
        check("waddr_idle", {20'd0, m_up_waddr}, 32'd0);
        check("wdata_idle", m_up_wdata, 32'd0);
      end
      if (m_up_rreq) begin
        rd_cnt++;
        rbusy = 1'b1;
        check("raddr", {20'd0, m_up_raddr}, 32'd1);
      end else if (rbusy) begin
        check("raddr_hold", {20'd0, m_up_raddr}, 32'd1);
      end else begin
        check("raddr_idle", {20'd0, m_up_raddr}, 32'd0);
      end

      m_up_wack  = 1'b0;
      m_up_rack  = 1'b0;
      m_up_rdata = 32'hA5A5_A5A4;
      if (wcnt > 0) begin wcnt--; if (wcnt == 0) m_up_wack = 1'b1; end
      if (m_up_wreq && !wack_hold) begin
        if (wack_lat == 0) m_up_wack = 1'b1; else wcnt = wack_lat;
      end
      if (rcnt > 0) begin rcnt--; if (rcnt == 0) m_up_rack = 1'b1; end
      if (m_up_rreq) begin
        if (rack_lat == 0) m_up_rack = 1'b1; else rcnt = rack_lat;
      end
      if (m_up_rack) m_up_rdata = (rd_cnt <= busy_reads) ? 32'h1 : 32'h0;
      if (spur && !wbusy && !rbusy && !m_up_wreq && !m_up_rreq) begin
        m_up_wack  = 1'b1;
        m_up_rack  = 1'b1;
        m_up_rdata = 32'h1;
      end
      if (m_up_wack) wbusy = 1'b0;
      if (m_up_rack) rbusy = 1'b0;
    end
  end

  // Push the writes the sequencer must issue; updates the divider cache model
  task automatic expect_writes(input logic [1:0] cs, input logic [7:0] d,
                               input logic [15:0] div, input bit hold);
    bit need_div;
    logic [31:0] ctrl;
    need_div = !(m_div_vld && (div == m_div));
    ctrl = 32'h0001_0800 | (32'(cs) << 1);
    if (need_div) begin
      wr_q.push_back('{addr: 12'd3, data: {16'd0, div}});
      if (hold) begin m_div_vld = 1'b0; return; end
      m_div = div;
      m_div_vld = 1'b1;
    end
    wr_q.push_back('{addr: 12'd0, data: ctrl});
    if (hold) return;
    wr_q.push_back('{addr: 12'd2, data: {24'd0, d}});
    wr_q.push_back('{addr: 12'd0, data: ctrl | 32'h9});
  endtask

  task automatic issue(input logic [1:0] cs, input logic [7:0] d, input logic [15:0] div);
    int n;
    n = 0;
    @(negedge up_clk);
    while (!cmd_ready && n < 100) begin @(negedge up_clk); n++; end
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_cs = cs; cmd_data = d; cmd_div = div; cmd_valid = 1'b1;
    @(posedge up_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start);
    int n;
    n = 0;
    while (rsp_seen == start && n < 5000) begin @(negedge up_clk); n++; end
    check("rsp_arrived", {31'd0, rsp_seen != start}, 32'd1);
  endtask

  task automatic do_cmd(input logic [1:0] cs, input logic [7:0] d, input logic [15:0] div,
                        input int busy, input bit hold);
    int   start;
    rsp_t e;
    busy_reads = busy;
    wack_hold  = hold;
    expect_writes(cs, d, div, hold);
    if (hold) e = '{data: 32'h0, err: 1'b1, reads: 0, tmo_chk: 1'b1};
    else if (busy >= POLL_MAX) e = '{data: 32'h1, err: 1'b1, reads: POLL_MAX, tmo_chk: 1'b0};
    else e = '{data: 32'h0, err: 1'b0, reads: busy + 1, tmo_chk: 1'b0};
    rsp_q.push_back(e);
    start = rsp_seen;
    issue(cs, d, div);
    wait_rsp(start);
    wack_hold = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    #1 up_rst = 1'b1;
    repeat (3) @(negedge up_clk);
    up_rst = 1'b0;
    @(negedge up_clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_wreq", {31'd0, m_up_wreq}, 32'd0);
    check("rst_rreq", {31'd0, m_up_rreq}, 32'd0);

    // Basic transfer, divider already matches the reset value
    do_cmd(2'd0, 8'h34, 16'h0004, 0, 1'b0);
    // New divider is written first, then cached
    do_cmd(2'd1, 8'h55, 16'h0008, 0, 1'b0);
    wack_lat = 0;
    do_cmd(2'd2, 8'hAA, 16'h0008, 0, 1'b0);
    wack_lat = 1;
    // Busy for five reads, slower rack
    rack_lat = 2;
    do_cmd(2'd3, 8'h5A, 16'h0008, 5, 1'b0);
    rack_lat = 1;

    // Stray acks while idle must be ignored
    spur = 1'b1;
    repeat (5) @(negedge up_clk);
    spur = 1'b0;
    check("spur_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Withheld wack on CTRL write, then a normal command
    do_cmd(2'd1, 8'h11, 16'h0008, 0, 1'b1);
    do_cmd(2'd1, 8'h12, 16'h0008, 1, 1'b0);
    // Timeout on the divider write invalidates the cache
    do_cmd(2'd0, 8'h21, 16'h0010, 0, 1'b1);
    do_cmd(2'd0, 8'h22, 16'h0010, 0, 1'b0);

    // Status stuck busy
    do_cmd(2'd2, 8'h33, 16'h0010, 1 << 30, 1'b0);

    // Reset while polling
    busy_reads = 1 << 30;
    expect_writes(2'd3, 8'h44, 16'h0010, 1'b0);
    start = rsp_seen;
    issue(2'd3, 8'h44, 16'h0010);
    n = 0;
    while (rd_cnt < 3 && n < 500) begin @(negedge up_clk); n++; end
    check("poll_reached", {31'd0, rd_cnt >= 3}, 32'd1);
    @(posedge up_clk);
    #2 up_rst = 1'b1;
    #1;
    check("mid_rst_wreq", {31'd0, m_up_wreq}, 32'd0);
    check("mid_rst_rreq", {31'd0, m_up_rreq}, 32'd0);
    check("mid_rst_raddr", {20'd0, m_up_raddr}, 32'd0);
    check("mid_rst_waddr", {20'd0, m_up_waddr}, 32'd0);
    check("mid_rst_wdata", m_up_wdata, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) begin
      @(negedge up_clk);
      check("rst_hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    up_rst = 1'b0;
    m_div = 16'h0004;
    m_div_vld = 1'b1;
    @(negedge up_clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_no_rsp", rsp_seen, start);
    // Divider back at its reset value: no divider write expected
    do_cmd(2'd1, 8'h66, 16'h0004, 2, 1'b0);

    repeat (5) @(negedge up_clk);
    check("wr_q_empty", wr_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/up_spi_seq.md
UP_SPI_SEQ -- requirements
Module: up_spi_seq

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, up-bus address width.
REQ-002 SHALL have parameter DIV_RESET, default 16'h0004, divider value assumed loaded after reset.
REQ-003 SHALL have parameter ACK_TMO, default 16, max cycles waiting for wack/rack.
REQ-004 SHALL have parameter POLL_MAX, default 1024, max status reads per transfer.
REQ-005 SHALL have ports: up_clk in 1, sole clock; up_rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_cs in 2, chip-select index; cmd_data in 8, tx byte; cmd_div in 16, SPI clock divider.
REQ-007 SHALL have ports: rsp_valid out 1, one-cycle pulse; rsp_data out 32, last status word; rsp_err out 1, timeout flag.
REQ-008 SHALL have master up-bus ports: m_up_wreq out 1; m_up_waddr out ADDRESS_WIDTH; m_up_wdata out 32; m_up_wack in 1; m_up_rreq out 1; m_up_raddr out ADDRESS_WIDTH; m_up_rdata in 32; m_up_rack in 1.

Function
REQ-009 SHALL use register map: 0 = control, 1 = status (bit0 busy), 2 = tx data, 3 = divider.
REQ-010 SHALL form control word CTRL = 32'h10800 | (cs<<1); GO word = CTRL | 32'h9.
REQ-011 SHALL accept a command only when cmd_valid && cmd_ready; cmd_ready high only in IDLE; fields latched on acceptance.
REQ-012 SHALL sequence states IDLE -> DIV -> SEL -> DATA -> GO -> POLL -> RSP -> IDLE.
REQ-013 SHALL skip DIV (IDLE -> SEL) when cmd_div equals the stored last-written divider.
REQ-014 SHALL, in DIV/SEL/DATA/GO, drive m_up_wreq high for exactly one cycle with address/data (3/div, 0/CTRL, 2/{24'd0,data}, 0/GO), then hold wreq low and wait for m_up_wack.
REQ-015 SHALL hold m_up_waddr/m_up_wdata stable from wreq until wack; zero them in all other cycles.
REQ-016 SHALL advance to the next state the cycle after wack; a wack arriving in the wreq cycle itself counts.
REQ-017 SHALL, in POLL, pulse m_up_rreq one cycle with raddr=1, wait rack, capture m_up_rdata; exit to RSP if bit0=0, else re-issue rreq the cycle after rack.
REQ-018 SHALL count ack-wait cycles; at ACK_TMO without ack, set error and go to RSP.
REQ-019 SHALL count status reads; on the POLL_MAX-th read still busy, set error and go to RSP.
REQ-020 SHALL, in RSP, pulse rsp_valid one cycle with rsp_data = last captured status (0 if none) and rsp_err; then return to IDLE.
REQ-021 SHALL, on timeout in DIV, invalidate the stored divider so the next command rewrites it.
REQ-022 SHALL ignore wack/rack arriving while not waiting for them.
REQ-023 SHALL never assert m_up_wreq and m_up_rreq in the same cycle.

Reset
REQ-024 SHALL, on up_rst, asynchronously enter IDLE; cmd_ready=1 after release; rsp_valid=0, rsp_data=0, rsp_err=0; all m_up_* outputs 0; counters 0; stored divider=DIV_RESET.
REQ-025 SHALL abandon any in-flight transfer on reset mid-operation without emitting rsp_valid.

Structure
REQ-026 SHALL place register addresses, CTRL base 32'h10800, GO mask 32'h9 and the state encoding in shared package up_spi_pkg.
REQ-027 SHALL implement the single-access handshake (pulse, wait, timeout) in sub-module up_bus_xfer, instantiated once and shared by write and read phases.

Verification
REQ-028 SHALL verify: cmd cs=0, data=8'h34, div=16'h0004, wack next cycle, status 0 -> writes (0,10800),(2,34),(0,10809) only, one read, rsp_valid with rsp_err=0.
REQ-029 SHALL verify: cmd div=16'h0008 -> first write (3,8); repeat same div -> no addr-3 write.
REQ-030 SHALL verify: cs=3, status busy for 5 reads then 0 -> CTRL 10806, GO 1080f, exactly 6 rreq pulses, rsp_data=0.
REQ-031 SHALL verify: wack withheld -> rsp_err=1 exactly ACK_TMO cycles after the unanswered wreq; next command proceeds normally.
REQ-032 SHALL verify: status stuck at 1 -> rsp_err=1 after POLL_MAX reads, rsp_data=32'h1.
REQ-033 SHALL verify: up_rst asserted during POLL -> outputs zero immediately, no rsp_valid, cmd_ready=1 after release.
